// File: rtl/modulo_controlador_partida.sv
// Game-phase sequencer: debounces the confirm button, runs IDLE/POSICIONAR/ATAQUE/FIM, strobes matrix loads, scores the game.
// Optional ATAQUE shot timeout is compiled in with CONTROLADOR_PARTIDA_TIMEOUT_EN.
module modulo_controlador_partida #(
    parameter int MAX_SHOTS     = 12,
    parameter int HIT_TARGET    = 5,
    parameter int DEB_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       button_clk,
    input  logic [1:0] hh1,
    input  logic [5:0] hh2,
    input  logic       po_hit,
    input  logic       at_done,
    output logic [1:0] state,
    output logic       po_load,
    output logic       at_load,
    output logic [5:0] at_addr,
    output logic       hit_pulse,
    output logic [3:0] hits,
    output logic [3:0] shots_left,
    output logic       game_over,
    output logic [1:0] result,
    output logic       err
);
    typedef enum logic [1:0] {IDLE = 2'b00, POSICIONAR = 2'b01, ATAQUE = 2'b10, FIM = 2'b11} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_SHOTS);
    localparam logic [3:0] HIT_T = 4'(HIT_TARGET);

    logic [1:0] sync_q;
    logic       deb_q, deb_prev_q;
    logic [3:0] deb_cnt_q;
    logic       press;

    state_t     state_q, state_d;
    logic       placed_q, placed_d;
    logic [3:0] hits_q, hits_d, shots_q, shots_d;
    logic [1:0] result_q, result_d;
    logic [5:0] at_addr_q, at_addr_d;
    logic       po_load_q, po_load_d, at_load_q, at_load_d;
    logic       hit_q, hit_d, err_q, err_d;
    logic       shot_ok, timeout_fire;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q     <= 2'b00;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= 4'd0;
        end else begin
            sync_q     <= {sync_q[0], button_clk};
            deb_prev_q <= deb_q;
            if (tick) begin
                // Level flips only after DEB_TICKS disagreeing samples in a row
                if (sync_q[1] != deb_q) begin
                    if (deb_cnt_q == 4'(DEB_TICKS - 1)) begin
                        deb_q     <= ~deb_q;
                        deb_cnt_q <= 4'd0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 4'd1;
                    end
                end else begin
                    deb_cnt_q <= 4'd0;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

`ifdef CONTROLADOR_PARTIDA_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d     = to_cnt_q;
        timeout_fire = 1'b0;
        if (state_q != ATAQUE || shot_ok) begin
            to_cnt_d = 8'd0;
        end else if (tick) begin
            if (to_cnt_q == 8'(TIMEOUT_TICKS - 1)) begin
                to_cnt_d     = 8'd0;
                timeout_fire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) to_cnt_q <= 8'd0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        placed_d  = placed_q;
        hits_d    = hits_q;
        shots_d   = shots_q;
        result_d  = result_q;
        at_addr_d = at_addr_q;
        po_load_d = 1'b0;
        at_load_d = 1'b0;
        hit_d     = 1'b0;
        err_d     = 1'b0;
        shot_ok   = 1'b0;
        if (press) begin
            case (state_q)
                IDLE: begin
                    if (hh1 == 2'b01) state_d = POSICIONAR;
                    else              err_d   = 1'b1;
                end
                POSICIONAR: begin
                    case (hh1)
                        2'b01: begin
                            po_load_d = 1'b1;
                            placed_d  = 1'b1;
                        end
                        2'b10: begin
                            if (placed_q) state_d = ATAQUE;
                            else          err_d   = 1'b1;
                        end
                        2'b00:   state_d = IDLE;
                        default: err_d   = 1'b1;
                    endcase
                end
                ATAQUE: begin
                    if (hh1 != 2'b10 || hh2[5:3] > 3'd6 || hh2[2:0] > 3'd4 || at_done) begin
                        err_d = 1'b1;
                    end else begin
                        shot_ok   = 1'b1;
                        at_load_d = 1'b1;
                        at_addr_d = hh2;
                        if (shots_q != 4'd0) shots_d = shots_q - 4'd1;
                        if (po_hit) begin
                            hit_d = 1'b1;
                            if (hits_q != HIT_T) hits_d = hits_q + 4'd1;
                        end
                    end
                end
                FIM: begin
                    if (hh1 == 2'b00) begin
                        state_d  = IDLE;
                        hits_d   = 4'd0;
                        shots_d  = MAX_S;
                        result_d = 2'b00;
                        placed_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // A forfeited shot only applies when no real shot was taken this cycle
        if (timeout_fire && !shot_ok) begin
            err_d = 1'b1;
            if (shots_q != 4'd0) shots_d = shots_q - 4'd1;
        end
        if (state_q == ATAQUE && (shot_ok || timeout_fire)) begin
            if (hits_d == HIT_T) begin
                state_d  = FIM;
                result_d = 2'b01;
            end else if (shots_d == 4'd0) begin
                state_d  = FIM;
                result_d = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            placed_q  <= 1'b0;
            hits_q    <= 4'd0;
            shots_q   <= MAX_S;
            result_q  <= 2'b00;
            at_addr_q <= 6'd0;
            po_load_q <= 1'b0;
            at_load_q <= 1'b0;
            hit_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            placed_q  <= placed_d;
            hits_q    <= hits_d;
            shots_q   <= shots_d;
            result_q  <= result_d;
            at_addr_q <= at_addr_d;
            po_load_q <= po_load_d;
            at_load_q <= at_load_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
        end
    end

    assign state      = state_q;
    assign po_load    = po_load_q;
    assign at_load    = at_load_q;
    assign at_addr    = at_addr_q;
    assign hit_pulse  = hit_q;
    assign hits       = hits_q;
    assign shots_left = shots_q;
    assign game_over  = (state_q == FIM);
    assign result     = result_q;
    assign err        = err_q;
endmodule

// File: tb/tb_modulo_controlador_partida.sv
// Bench for the game sequencer: scripted game scenarios plus random presses checked against a rule-level game model.
module tb_modulo_controlador_partida;
    localparam int MAXS = 12;
    localparam int HITT = 5;
    localparam int DEB  = 4;

    logic       clk = 1'b0, clr = 1'b1, tick = 1'b0, button_clk = 1'b0;
    logic [1:0] hh1 = 2'b00;
    logic [5:0] hh2 = 6'd0;
    logic       po_hit = 1'b0, at_done = 1'b0;
    logic [1:0] state, result;
    logic       po_load, at_load, hit_pulse, game_over, err;
    logic [5:0] at_addr;
    logic [3:0] hits, shots_left;

    modulo_controlador_partida dut (
        .clk(clk), .clr(clr), .tick(tick), .button_clk(button_clk),
        .hh1(hh1), .hh2(hh2), .po_hit(po_hit), .at_done(at_done),
        .state(state), .po_load(po_load), .at_load(at_load), .at_addr(at_addr),
        .hit_pulse(hit_pulse), .hits(hits), .shots_left(shots_left),
        .game_over(game_over), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int n_err = 0, n_po = 0, n_at = 0, n_hit = 0;

    always @(negedge clk) begin
        if (!clr) begin
            if (err)       n_err++;
            if (po_load)   n_po++;
            if (at_load)   n_at++;
            if (hit_pulse) n_hit++;
        end
    end

    // Reference game model
    int m_state, m_hits, m_shots, m_result, m_placed, m_addr;
    int e_err, e_po, e_at, e_hit;
    int d_err, d_po, d_at, d_hit;
    logic [15:0] obs_str, exp_str;
    logic [18:0] obs_st, exp_st;

    task automatic model_reset();
        m_state = 0; m_hits = 0; m_shots = MAXS; m_result = 0; m_placed = 0; m_addr = 0;
    endtask

    task automatic model_press(input int h1, input int h2, input int ph, input int ad);
        e_err = 0; e_po = 0; e_at = 0; e_hit = 0;
        case (m_state)
            0: if (h1 == 1) m_state = 1; else e_err = 1;
            1: begin
                if (h1 == 1) begin e_po = 1; m_placed = 1; end
                else if (h1 == 2 && m_placed == 1) m_state = 2;
                else if (h1 == 0) m_state = 0;
                else e_err = 1;
            end
            2: begin
                if (h1 != 2 || (h2 / 8) > 6 || (h2 % 8) > 4 || ad == 1) e_err = 1;
                else begin
                    e_at = 1;
                    m_addr = h2;
                    m_shots = (m_shots > 0) ? m_shots - 1 : 0;
                    if (ph == 1) begin
                        e_hit = 1;
                        m_hits = (m_hits < HITT) ? m_hits + 1 : HITT;
                    end
                    if (m_hits == HITT) begin m_state = 3; m_result = 1; end
                    else if (m_shots == 0) begin m_state = 3; m_result = 2; end
                end
            end
            default: begin
                if (h1 == 0) begin
                    m_state = 0; m_hits = 0; m_shots = MAXS; m_result = 0; m_placed = 0;
                end else e_err = 1;
            end
        endcase
    endtask

    task automatic tick_once();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic hold_button(input logic v, input int nticks);
        button_clk = v;
        repeat (nticks) tick_once();
    endtask

    // Drives one clean press/release and computes observed and expected pulse counts and status
    task automatic do_press(input int h1, input int h2, input int ph, input int ad);
        int b_err, b_po, b_at, b_hit;
        b_err = n_err; b_po = n_po; b_at = n_at; b_hit = n_hit;
        model_press(h1, h2, ph, ad);
        hh1 = 2'(h1); hh2 = 6'(h2); po_hit = ph[0]; at_done = ad[0];
        hold_button(1'b1, DEB + 3);
        hold_button(1'b0, DEB + 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        d_err = n_err - b_err; d_po = n_po - b_po; d_at = n_at - b_at; d_hit = n_hit - b_hit;
        obs_str = {4'(d_err), 4'(d_po), 4'(d_at), 4'(d_hit)};
        exp_str = {4'(e_err), 4'(e_po), 4'(e_at), 4'(e_hit)};
        obs_st  = {state, hits, shots_left, result, game_over, at_addr};
        exp_st  = {2'(m_state), 4'(m_hits), 4'(m_shots), 2'(m_result), (m_state == 3), 6'(m_addr)};
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({state, hits, shots_left, result, game_over, at_addr} !== {2'b00, 4'd0, 4'(MAXS), 2'b00, 1'b0, 6'd0})
            $display("FAIL reset_status: got st=%0d hits=%0d shots=%0d res=%0d go=%0b addr=%0h, want 0/0/%0d/0/0/0",
                     state, hits, shots_left, result, game_over, at_addr, MAXS);
        else n_pass++;
        n_checks++;
        if ({po_load, at_load, hit_pulse, err} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {po_load, at_load, hit_pulse, err});
        else n_pass++;
    endtask

    task automatic test_debounce();
        int b_err;
        b_err = n_err;
        hh1 = 2'b01;
        hold_button(1'b1, 2); hold_button(1'b0, 1);
        hold_button(1'b1, 2); hold_button(1'b0, DEB + 2);
        @(negedge clk);
        n_checks++;
        if (state !== 2'b00 || n_err != b_err)
            $display("FAIL bounce_rejected: got state=%0d errs=%0d want state=0 errs=0", state, n_err - b_err);
        else n_pass++;
        // Long hold must yield exactly one press
        b_err = n_err;
        model_press(1, 0, 0, 0);
        hold_button(1'b1, 3 * DEB);
        hold_button(1'b0, DEB + 3);
        @(negedge clk);
        n_checks++;
        if (state !== 2'b01 || n_po != 0 || n_err != b_err)
            $display("FAIL single_press: got state=%0d po=%0d errs=%0d want state=1 po=0 errs=0", state, n_po, n_err - b_err);
        else n_pass++;
    endtask

    task automatic test_position();
        int tab_h1 [3] = '{2, 1, 2};
        int tab_st [3] = '{1, 1, 2};
        for (int i = 0; i < 3; i++) begin
            do_press(tab_h1[i], 0, 0, 0);
            n_checks++;
            if (obs_str !== exp_str || state !== 2'(tab_st[i]))
                $display("FAIL position_%0d: got str=%h state=%0d want str=%h state=%0d", i, obs_str, state, exp_str, tab_st[i]);
            else n_pass++;
        end
    endtask

    task automatic test_attack_win();
        int cells [4] = '{6'o00, 6'o14, 6'o61, 6'o32};
        do_press(2, 6'b111_000, 1, 0);
        n_checks++;
        if (d_err != 1 || d_at != 0 || shots_left !== 4'd12)
            $display("FAIL bad_line: got err=%0d at=%0d shots=%0d want 1/0/12", d_err, d_at, shots_left);
        else n_pass++;
        do_press(2, 6'b010_011, 1, 0);
        n_checks++;
        if (obs_str !== 16'h0011 || at_addr !== 6'b010_011 || hits !== 4'd1 || shots_left !== 4'd11)
            $display("FAIL first_hit: got str=%h addr=%h hits=%0d shots=%0d want 0011/13/1/11", obs_str, at_addr, hits, shots_left);
        else n_pass++;
        do_press(2, 6'b010_011, 1, 1);
        n_checks++;
        if (obs_str !== exp_str || obs_st !== exp_st)
            $display("FAIL repeat_cell: got str=%h st=%h want str=%h st=%h", obs_str, obs_st, exp_str, exp_st);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            do_press(2, cells[i], 1, 0);
            n_checks++;
            if (obs_str !== exp_str || obs_st !== exp_st)
                $display("FAIL hit_%0d: got str=%h st=%h want str=%h st=%h", i, obs_str, obs_st, exp_str, exp_st);
            else n_pass++;
        end
        n_checks++;
        if ({state, result, game_over, hits} !== {2'b11, 2'b01, 1'b1, 4'd5})
            $display("FAIL win: got state=%0d res=%0d go=%0b hits=%0d want 3/1/1/5", state, result, game_over, hits);
        else n_pass++;
    endtask

    task automatic test_lose_restart();
        int seq [5] = '{2, 0, 1, 1, 2};
        for (int i = 0; i < 5; i++) begin
            do_press(seq[i], 0, 0, 0);
            n_checks++;
            if (obs_str !== exp_str || obs_st !== exp_st)
                $display("FAIL setup_%0d: got str=%h st=%h want str=%h st=%h", i, obs_str, obs_st, exp_str, exp_st);
            else n_pass++;
        end
        for (int i = 0; i < MAXS; i++) begin
            do_press(2, (i % 7) * 8 + (i % 5), 0, 0);
            n_checks++;
            if (obs_str !== exp_str || obs_st !== exp_st)
                $display("FAIL miss_%0d: got str=%h st=%h want str=%h st=%h", i, obs_str, obs_st, exp_str, exp_st);
            else n_pass++;
        end
        n_checks++;
        if ({state, result, shots_left, hits} !== {2'b11, 2'b10, 4'd0, 4'd0})
            $display("FAIL lose: got state=%0d res=%0d shots=%0d hits=%0d want 3/2/0/0", state, result, shots_left, hits);
        else n_pass++;
        do_press(0, 0, 0, 0);
        n_checks++;
        if ({state, result, shots_left, hits, game_over} !== {2'b00, 2'b00, 4'(MAXS), 4'd0, 1'b0})
            $display("FAIL restart: got state=%0d res=%0d shots=%0d hits=%0d want 0/0/%0d/0", state, result, shots_left, hits, MAXS);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int b_sum;
        do_press(1, 0, 0, 0); do_press(1, 0, 0, 0); do_press(2, 0, 0, 0);
        do_press(2, 6'o11, 1, 0);
        b_sum = n_err + n_po + n_at + n_hit;
        @(posedge clk); #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({state, hits, shots_left, result, at_addr} !== {2'b00, 4'd0, 4'(MAXS), 2'b00, 6'd0} || n_err + n_po + n_at + n_hit != b_sum)
            $display("FAIL reset_abort: got state=%0d hits=%0d shots=%0d res=%0d addr=%h extra_strobes=%0d want idle/0/%0d/0/0/0",
                     state, hits, shots_left, result, at_addr, n_err + n_po + n_at + n_hit - b_sum, MAXS);
        else n_pass++;
    endtask

    task automatic test_random();
        int h1, h2, ph, ad;
        for (int i = 0; i < 70; i++) begin
            if ($urandom_range(0, 3) == 0) h1 = $urandom_range(0, 3);
            else case (m_state)
                0: h1 = 1;
                1: h1 = ($urandom_range(0, 1) == 0) ? 1 : 2;
                2: h1 = 2;
                default: h1 = 0;
            endcase
            h2 = $urandom_range(0, 63);
            ph = $urandom_range(0, 1);
            ad = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_press(h1, h2, ph, ad);
            n_checks++;
            if (obs_str !== exp_str || obs_st !== exp_st)
                $display("FAIL random_%0d (hh1=%0d hh2=%h ph=%0d ad=%0d): got str=%h st=%h want str=%h st=%h",
                         i, h1, h2, ph, ad, obs_str, obs_st, exp_str, exp_st);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_position();
        test_attack_win();
        test_lose_restart();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
